// File: rtl/enemy_ammo_pkg.sv
// -----------------------------------------------------------------------------
// enemy_ammo_pkg
// Shared types and constants for the enemy projectile controller.
//   COORD_W      : width of every screen coordinate
//   DEF_*        : default screen / sprite geometry
//   slot_t       : state of one projectile slot (active flag + top-left x/y)
//   SLOT_RESET   : value of a slot after reset (inactive at the origin)
// -----------------------------------------------------------------------------
package enemy_ammo_pkg;

    localparam int COORD_W      = 10;
    localparam int DEF_SCREEN_H = 480;
    localparam int DEF_AMMO_W   = 8;
    localparam int DEF_AMMO_H   = 8;

    typedef struct packed {
        logic               active;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } slot_t;

    localparam slot_t SLOT_RESET = '{active: 1'b0, x: '0, y: '0};

endpackage

// File: rtl/enemy_ammo_slot.sv
// -----------------------------------------------------------------------------
// enemy_ammo_slot
// One projectile slot: holds its state, applies clear / spawn / move, and
// tests the current scan pixel against its sprite box.
// Ports:
//   Clk, Reset          : clock, asynchronous active-high reset
//   spawn               : load spawn_x/spawn_y and become active
//   move                : frame tick, move down by SPEED (retire past bottom)
//   clear               : retire; wins over spawn and move
//   spawn_x, spawn_y    : spawn origin (sprite top-left)
//   draw_x, draw_y      : current scan pixel
//   active, x, y        : registered slot state
//   hit                 : scan pixel lies inside this active sprite
//   rel_addr            : sprite ROM address of the pixel (valid when hit)
// -----------------------------------------------------------------------------
module enemy_ammo_slot
    import enemy_ammo_pkg::*;
#(
    parameter int AMMO_W   = DEF_AMMO_W,
    parameter int AMMO_H   = DEF_AMMO_H,
    parameter int SPEED    = 2,
    parameter int SCREEN_H = DEF_SCREEN_H,
    parameter int ADDR_W   = 6
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               spawn,
    input  logic               move,
    input  logic               clear,
    input  logic [COORD_W-1:0] spawn_x,
    input  logic [COORD_W-1:0] spawn_y,
    input  logic [COORD_W-1:0] draw_x,
    input  logic [COORD_W-1:0] draw_y,
    output logic               active,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               hit,
    output logic [ADDR_W-1:0]  rel_addr
);

    slot_t            slot_q, slot_d;
    logic [COORD_W:0] moved_y;
    logic [COORD_W:0] dx, dy;
    logic [COORD_W:0] x_end, y_end;

    // NOTE: every signal written here gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        slot_d  = slot_q;
        moved_y = {1'b0, slot_q.y} + (COORD_W+1)'(SPEED);

        if (clear) begin
            slot_d.active = 1'b0;
        end else if (spawn) begin
            slot_d = '{active: 1'b1, x: spawn_x, y: spawn_y};
        end else if (move && slot_q.active) begin
            // Sum is one bit wider so running off the bottom never wraps.
            if (moved_y > (COORD_W+1)'(SCREEN_H - 1)) begin
                slot_d.active = 1'b0;
            end else begin
                slot_d.y = moved_y[COORD_W-1:0];
            end
        end
    end

    // NOTE: reset is asynchronous, so it sits in the sensitivity list;
    // the state register uses non-blocking assignments only.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            slot_q <= SLOT_RESET;
        end else begin
            slot_q <= slot_d;
        end
    end

    // Box test in COORD_W+1 bits so a sprite near x/y=1023 does not wrap.
    always_comb begin
        x_end    = {1'b0, slot_q.x} + (COORD_W+1)'(AMMO_W);
        y_end    = {1'b0, slot_q.y} + (COORD_W+1)'(AMMO_H);
        dx       = {1'b0, draw_x} - {1'b0, slot_q.x};
        dy       = {1'b0, draw_y} - {1'b0, slot_q.y};
        hit      = slot_q.active
                 && (draw_x >= slot_q.x) && ({1'b0, draw_x} < x_end)
                 && (draw_y >= slot_q.y) && ({1'b0, draw_y} < y_end);
        rel_addr = ADDR_W'(dy * AMMO_W + dx);
    end

    assign active = slot_q.active;
    assign x      = slot_q.x;
    assign y      = slot_q.y;

endmodule

// File: rtl/enemy_ammo_controller.sv
// -----------------------------------------------------------------------------
// enemy_ammo_controller
// Owns all live enemy projectiles: periodic spawning from the enemy,
// per-frame downward motion, retirement at the bottom edge or on collision,
// and a 2-stage per-pixel path producing the sprite ROM address and the
// palette index / coverage flag for the current scan pixel.
// Ports:
//   Clk, Reset            : clock, asynchronous active-high reset
//   frame_start           : one-cycle pulse at start of vertical blank
//   enemy_x, enemy_y      : spawn origin (sprite top-left)
//   enemy_alive           : firing enabled
//   hit_clear             : per-slot retire request from collision logic
//   DrawX, DrawY          : current scan pixel
//   rom_addr              : registered sprite ROM address
//   rom_data              : sprite ROM output, one cycle after rom_addr
//   ammo_on, ammo_index   : pixel covered / palette index (2-cycle latency)
//   ammo_active           : slot occupancy
//   ammo_x, ammo_y        : packed slot positions, slot i at [i*10 +: 10]
// Build option: define ENEMY_AMMO_TRANSPARENCY_EN to treat palette index 0
// as transparent (ammo_on forced low for such pixels).
// -----------------------------------------------------------------------------
module enemy_ammo_controller
    import enemy_ammo_pkg::*;
#(
    parameter int NUM_SHOTS   = 4,
    parameter int AMMO_W      = DEF_AMMO_W,
    parameter int AMMO_H      = DEF_AMMO_H,
    parameter int SPEED       = 2,
    parameter int FIRE_PERIOD = 60,
    parameter int SCREEN_H    = DEF_SCREEN_H,
    localparam int ADDR_W     = $clog2(AMMO_W * AMMO_H)
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         frame_start,
    input  logic [COORD_W-1:0]           enemy_x,
    input  logic [COORD_W-1:0]           enemy_y,
    input  logic                         enemy_alive,
    input  logic [NUM_SHOTS-1:0]         hit_clear,
    input  logic [COORD_W-1:0]           DrawX,
    input  logic [COORD_W-1:0]           DrawY,
    output logic [ADDR_W-1:0]            rom_addr,
    input  logic [3:0]                   rom_data,
    output logic                         ammo_on,
    output logic [3:0]                   ammo_index,
    output logic [NUM_SHOTS-1:0]         ammo_active,
    output logic [NUM_SHOTS*COORD_W-1:0] ammo_x,
    output logic [NUM_SHOTS*COORD_W-1:0] ammo_y
);

    localparam int             FC_W      = (FIRE_PERIOD > 1) ? $clog2(FIRE_PERIOD) : 1;
    localparam logic [FC_W-1:0] FIRE_LAST = FC_W'(FIRE_PERIOD - 1);

    logic [FC_W-1:0]      fire_cnt_q, fire_cnt_d;
    logic                 fire_attempt;
    logic                 spawn_found;
    logic [NUM_SHOTS-1:0] spawn_vec;
    logic [NUM_SHOTS-1:0] slot_active;
    logic [NUM_SHOTS-1:0] slot_hit;
    logic [ADDR_W-1:0]    slot_addr [NUM_SHOTS];

    logic [ADDR_W-1:0]    rom_addr_q, rom_addr_d;
    logic                 hit1_q, hit1_d;
    logic                 ammo_on_q, ammo_on_d;

    // ---------------- fire timer ----------------
    always_comb begin
        fire_cnt_d   = fire_cnt_q;
        fire_attempt = 1'b0;
        if (frame_start) begin
            if (fire_cnt_q == FIRE_LAST) begin
                fire_cnt_d   = '0;
                fire_attempt = 1'b1;
            end else begin
                fire_cnt_d = fire_cnt_q + 1'b1;
            end
        end
    end

    // Lowest free slot takes the shot; a slot being cleared this cycle still
    // counts as occupied, so the shot is dropped rather than landing there.
    always_comb begin
        spawn_vec   = '0;
        spawn_found = 1'b0;
        for (int i = 0; i < NUM_SHOTS; i++) begin
            if (!spawn_found && fire_attempt && enemy_alive
                && !slot_active[i] && !hit_clear[i]) begin
                spawn_vec[i] = 1'b1;
                spawn_found  = 1'b1;
            end
        end
    end

    // ---------------- slots ----------------
    for (genvar g = 0; g < NUM_SHOTS; g++) begin : g_slot
        enemy_ammo_slot #(
            .AMMO_W   (AMMO_W),
            .AMMO_H   (AMMO_H),
            .SPEED    (SPEED),
            .SCREEN_H (SCREEN_H),
            .ADDR_W   (ADDR_W)
        ) u_slot (
            .Clk      (Clk),
            .Reset    (Reset),
            .spawn    (spawn_vec[g]),
            .move     (frame_start),
            .clear    (hit_clear[g]),
            .spawn_x  (enemy_x),
            .spawn_y  (enemy_y),
            .draw_x   (DrawX),
            .draw_y   (DrawY),
            .active   (slot_active[g]),
            .x        (ammo_x[g*COORD_W +: COORD_W]),
            .y        (ammo_y[g*COORD_W +: COORD_W]),
            .hit      (slot_hit[g]),
            .rel_addr (slot_addr[g])
        );
    end

    // ---------------- pixel pipeline ----------------
    // Walking from the highest index down lets the lowest hitting slot
    // overwrite the others, giving lowest-index priority without a flag.
    always_comb begin
        rom_addr_d = '0;
        hit1_d     = 1'b0;
        for (int i = NUM_SHOTS - 1; i >= 0; i--) begin
            if (slot_hit[i]) begin
                hit1_d     = 1'b1;
                rom_addr_d = slot_addr[i];
            end
        end
        ammo_on_d = hit1_q;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fire_cnt_q <= '0;
            rom_addr_q <= '0;
            hit1_q     <= 1'b0;
            ammo_on_q  <= 1'b0;
        end else begin
            fire_cnt_q <= fire_cnt_d;
            rom_addr_q <= rom_addr_d;
            hit1_q     <= hit1_d;
            ammo_on_q  <= ammo_on_d;
        end
    end

    assign rom_addr    = rom_addr_q;
    assign ammo_index  = rom_data;
    assign ammo_active = slot_active;

    // rom_data arrives in the same cycle as ammo_on_q, so the transparency
    // test is applied on the output rather than before the register.
`ifdef ENEMY_AMMO_TRANSPARENCY_EN
    assign ammo_on = ammo_on_q && (rom_data != 4'h0);
`else
    assign ammo_on = ammo_on_q;
`endif

endmodule

// File: tb/tb_enemy_ammo_controller.sv
// -----------------------------------------------------------------------------
// tb_enemy_ammo_controller
// Directed bench for enemy_ammo_controller (FIRE_PERIOD=3, other defaults).
// Pixel requests push their expected rom_addr / ammo_on / ammo_index into
// queues; a monitor pops and compares them when the pipeline delivers.
// The sprite ROM model returns the low nibble of the address one cycle later.
// -----------------------------------------------------------------------------
module tb_enemy_ammo_controller;

    localparam int NS = 4;
    localparam int AW = 6;

    logic           Clk = 1'b0;
    logic           Reset;
    logic           frame_start;
    logic [9:0]     enemy_x, enemy_y;
    logic           enemy_alive;
    logic [NS-1:0]  hit_clear;
    logic [9:0]     DrawX, DrawY;
    logic [AW-1:0]  rom_addr;
    logic [3:0]     rom_data;
    logic           ammo_on;
    logic [3:0]     ammo_index;
    logic [NS-1:0]  ammo_active;
    logic [NS*10-1:0] ammo_x, ammo_y;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        int          due;
        logic [AW-1:0] addr;
        logic        on;
        logic [3:0]  idx;
        string       name;
    } pix_t;

    pix_t addr_q[$];
    pix_t pix_q[$];
    pix_t mon_a, mon_p;

    enemy_ammo_controller #(
        .NUM_SHOTS   (NS),
        .FIRE_PERIOD (3)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_start (frame_start),
        .enemy_x     (enemy_x),
        .enemy_y     (enemy_y),
        .enemy_alive (enemy_alive),
        .hit_clear   (hit_clear),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .ammo_on     (ammo_on),
        .ammo_index  (ammo_index),
        .ammo_active (ammo_active),
        .ammo_x      (ammo_x),
        .ammo_y      (ammo_y)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc++;

    // Synchronous sprite ROM: index = low nibble of the address.
    always @(posedge Clk) rom_data <= rom_addr[3:0];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge Clk) begin
        while (addr_q.size() > 0 && addr_q[0].due == cyc) begin
            mon_a = addr_q.pop_front();
            check({mon_a.name, "_rom_addr"}, 64'(rom_addr), 64'(mon_a.addr));
        end
        while (pix_q.size() > 0 && pix_q[0].due == cyc) begin
            mon_p = pix_q.pop_front();
            check({mon_p.name, "_ammo_on"},    64'(ammo_on),    64'(mon_p.on));
            check({mon_p.name, "_ammo_index"}, 64'(ammo_index), 64'(mon_p.idx));
        end
    end

    function automatic logic [9:0] sx(input int i);
        return ammo_x[i*10 +: 10];
    endfunction

    function automatic logic [9:0] sy(input int i);
        return ammo_y[i*10 +: 10];
    endfunction

    task automatic frame(input logic [NS-1:0] hc);
        @(negedge Clk);
        frame_start = 1'b1;
        hit_clear   = hc;
        @(negedge Clk);
        frame_start = 1'b0;
        hit_clear   = '0;
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) frame('0);
    endtask

    task automatic pixel(input string name, input int x, input int y,
                         input logic exp_hit, input int exp_addr);
        pix_t e;
        logic [AW-1:0] a;
        a = AW'(exp_addr);
        @(negedge Clk);
        DrawX = 10'(x);
        DrawY = 10'(y);
        e.name = name;
        e.addr = a;
        e.idx  = a[3:0];
`ifdef ENEMY_AMMO_TRANSPARENCY_EN
        e.on   = exp_hit && (a[3:0] != 4'h0);
`else
        e.on   = exp_hit;
`endif
        e.due = cyc + 1;
        addr_q.push_back(e);
        e.due = cyc + 2;
        pix_q.push_back(e);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 10 && (addr_q.size() + pix_q.size()) > 0; i++) @(negedge Clk);
        check({name, "_drain"}, 64'(addr_q.size() + pix_q.size()), 64'd0);
        DrawX = 10'd1023;
        DrawY = 10'd1023;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset       = 1'b1;
        frame_start = 1'b0;
        enemy_x     = 10'd100;
        enemy_y     = 10'd50;
        enemy_alive = 1'b1;
        hit_clear   = '0;
        DrawX       = 10'd1023;
        DrawY       = 10'd1023;
        repeat (2) @(negedge Clk);

        check("rst_active",   64'(ammo_active), 64'd0);
        check("rst_x",        64'(ammo_x),      64'd0);
        check("rst_y",        64'(ammo_y),      64'd0);
        check("rst_rom_addr", 64'(rom_addr),    64'd0);
        check("rst_ammo_on",  64'(ammo_on),     64'd0);
        @(negedge Clk);
        Reset = 1'b0;

        // Fire period 3: frames 1,2 no shot, frame 3 spawns into slot 0.
        frames(2);
        check("no_fire_early", 64'(ammo_active), 64'd0);
        frame('0);
        check("spawn_active", 64'(ammo_active), 64'b0001);
        check("spawn_x0",     64'(sx(0)),       64'd100);
        check("spawn_y0",     64'(sy(0)),       64'd50);
        frame('0);
        check("move_y0",      64'(sy(0)),       64'd52);
        check("move_active",  64'(ammo_active), 64'b0001);

        // Pixel path against slot 0 at (100,52).
        pixel("px_inside",   103, 54, 1'b1, 19);
        pixel("px_right",    108, 54, 1'b0, 0);
        pixel("px_origin",   100, 52, 1'b1, 0);
        pixel("px_corner",   107, 59, 1'b1, 63);
        pixel("px_below",    107, 60, 1'b0, 0);
        pixel("px_left",      99, 52, 1'b0, 0);
        drain("px1");

        // Fill the remaining slots (spawns at frames 6, 9, 12).
        enemy_x = 10'd200;
        enemy_y = 10'd100;
        frames(8);
        check("fill_active", 64'(ammo_active), 64'b1111);
        check("fill_x3",     64'(sx(3)),       64'd200);
        check("fill_y3",     64'(sy(3)),       64'd100);
        check("fill_y0",     64'(sy(0)),       64'd68);

        // Frame 15: fire with no free slot, shot dropped.
        frames(3);
        check("full_active", 64'(ammo_active), 64'b1111);
        check("full_y3",     64'(sy(3)),       64'd106);
        check("full_y0",     64'(sy(0)),       64'd74);
        check("full_x0",     64'(sx(0)),       64'd100);

        // Frame 18: fire together with clear of slot 1 -> slot 1 retired, shot dropped.
        frames(2);
        frame(4'b0010);
        check("clr_fire_active", 64'(ammo_active), 64'b1101);

        // Frame 21: slot 1 reused.
        enemy_x = 10'd300;
        enemy_y = 10'd10;
        frames(3);
        check("respawn_active", 64'(ammo_active), 64'b1111);
        check("respawn_x1",     64'(sx(1)),       64'd300);
        check("respawn_y1",     64'(sy(1)),       64'd10);

        // Clear outside a frame pulse.
        @(negedge Clk);
        hit_clear = 4'b0001;
        @(negedge Clk);
        hit_clear = '0;
        check("idle_clear", 64'(ammo_active), 64'b1110);

        // Frame 24: spawn at y=478 into slot 0; frame 25 pushes it to 480.
        enemy_x = 10'd40;
        enemy_y = 10'd478;
        frames(3);
        check("edge_spawn_active", 64'(ammo_active), 64'b1111);
        check("edge_spawn_y0",     64'(sy(0)),       64'd478);
        frame('0);
        check("edge_exit_active",  64'(ammo_active), 64'b1110);
        check("edge_y2",           64'(sy(2)),       64'd132);
        check("edge_y3",           64'(sy(3)),       64'd126);

        // Overlapping slots 2 (200,132) and 3 (200,126): lowest index wins.
        pixel("px_prio",     201, 133, 1'b1, 9);
        pixel("px_slot3",    202, 131, 1'b1, 42);
        pixel("px_inactive",  41, 479, 1'b0, 0);
        drain("px2");

        // Frame 27: spawn at y=477; frame 28 lands exactly on 479 and stays.
        enemy_y = 10'd477;
        frames(2);
        check("b477_y0",     64'(sy(0)),       64'd477);
        frame('0);
        check("b479_active", 64'(ammo_active), 64'b1111);
        check("b479_y0",     64'(sy(0)),       64'd479);

        // Frame 29 retires slot 0; frame 30 fires with enemy dead -> no spawn.
        enemy_alive = 1'b0;
        frames(2);
        check("dead_active", 64'(ammo_active), 64'b1110);
        check("dead_y1",     64'(sy(1)),       64'd28);

        // Mid-cycle asynchronous reset with a hit in the pipeline (slot 2 at 200,142).
        @(negedge Clk);
        DrawX = 10'd201;
        DrawY = 10'd143;
        repeat (2) @(negedge Clk);
        check("pre_rst_rom_addr", 64'(rom_addr), 64'd9);
        check("pre_rst_ammo_on",  64'(ammo_on),  64'd1);
        #2 Reset = 1'b1;
        #1;
        check("async_rst_active",   64'(ammo_active), 64'd0);
        check("async_rst_y",        64'(ammo_y),      64'd0);
        check("async_rst_rom_addr", 64'(rom_addr),    64'd0);
        check("async_rst_ammo_on",  64'(ammo_on),     64'd0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
